byte_mem_ctrl: RTL and testbench
================================

BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width; depth = 2**ADDR_W bytes.
REQ-002 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8, 8..64; NB = DATA_W/8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles after acceptance; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address of lane 0.
REQ-010 SHALL have port req_be, input, NB, byte enables, where bit i selects lane i.
REQ-011 SHALL have port req_wdata, input, DATA_W, write data, little-endian, with lane i = bits [8i+7:8i].
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err, output, 1, request rejected.

Function
REQ-016 SHALL accept a request on a cycle with req_valid and req_ready both high; one request outstanding at most.
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
  - req_ready is high only in IDLE.
  - On acceptance: IDLE -> WAIT, with latency counter loaded to RD_LAT-1.
  - WAIT with counter 0 -> RESP; otherwise the counter decrements.
REQ-018 SHALL treat writes with RD_LAT=1 timing regardless of parameter value; the response follows in RESP.
REQ-019 SHALL commit a write on the acceptance edge: byte addr+i <= lane i for each set req_be[i]; disabled lanes are unchanged.
REQ-020 SHALL return read data with rsp_valid rising exactly RD_LAT+1 cycles after the acceptance edge; lane i = byte addr+i when req_be[i] is set, else 0.
REQ-021 SHALL compute byte addresses modulo 2**ADDR_W, so an access at the top of memory wraps to address 0.
REQ-022 SHALL capture the request fields at acceptance; input changes during WAIT/RESP have no effect.
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready is high; RESP -> IDLE on that edge.
REQ-024 SHALL flag rsp_err=1 with no memory change when req_be is all-zero.
REQ-025 SHALL let a read of an address written by the immediately preceding request return the new data (no hazard), because ordering is serialised.
REQ-026 SHALL register rsp_valid, rsp_rdata and rsp_err; there is no combinational path from req_* to rsp_*.

Reset
REQ-027 SHALL, on rst, asynchronously force: state IDLE, counter 0, req_ready 1 after release, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-028 SHALL not reset memory contents; a write accepted before rst stays committed, and a pending read response is discarded.

Configuration
REQ-029 SHALL provide macro BYTE_MEM_ALIGN_CHECK_EN.
  - Defined: a request whose req_addr is not a multiple of NB is rejected with rsp_err=1, rdata 0 and no write.
  - Undefined: misaligned accesses proceed byte-wise per REQ-019..021.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, WAIT, RESP) and the RD_LAT legal-range constants in shared package byte_mem_pkg.
REQ-031 SHALL isolate the byte array in one sub-module, byte_mem_array: NB write ports with per-lane enable and combinational NB-lane read; controller logic lives in byte_mem_ctrl.

Verification
REQ-032 SHALL cover write then read: write addr 0x010, be 4'b1111, data 0xDEADBEEF; read 0x010 -> rdata 0xDEADBEEF, err 0, rsp_valid at acceptance+RD_LAT+1.
REQ-033 SHALL cover partial write: be 4'b0101, data 0x11223344 over 0xDEADBEEF at 0x020 -> read returns 0xDE22BE44.
REQ-034 SHALL cover wrap: ADDR_W=10, write 0x3FE with data 0xAABBCCDD -> byte 0x3FE=DD, 0x3FF=CC, 0x000=BB, 0x001=AA (macro undefined).
REQ-035 SHALL cover misalign: macro defined, read 0x013 -> err 1, rdata 0; write 0x013 -> err 1, memory unchanged.
REQ-036 SHALL cover backpressure: hold rsp_ready=0 for 5 cycles -> response stable and req_ready 0 throughout; next request accepted only after the rsp_ready edge.
REQ-037 SHALL cover reset mid-read: assert rst in WAIT -> rsp_valid 0 immediately, no response after release, and previously written data intact.

Source files
------------

// File: rtl/byte_mem_pkg.sv
// Shared FSM state type and read-latency limits for the byte memory controller.
package byte_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/byte_mem_if.sv
// Request/response bus of the byte memory controller; master drives requests.
interface byte_mem_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [NB-1:0]     req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/byte_mem_array.sv
// Byte-wide storage with NB per-lane write enables and a combinational NB-lane read.
module byte_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W/8-1:0] we,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  // Lane addresses are ADDR_W bits wide, so lanes past the top wrap to 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[waddr + ADDR_W'(i)] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      rdata[8*i +: 8] = mem[raddr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Single-outstanding byte-enable memory controller with registered responses.
// Optional BYTE_MEM_ALIGN_CHECK_EN rejects requests whose address is not NB-aligned.
module byte_mem_ctrl
  import byte_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic       clk,
  input logic       rst,
  byte_mem_if.slave bus
);
  localparam int NB = DATA_W / 8;
  // Out-of-range latencies are clamped so the counter can never overflow.
  localparam int LAT_EFF = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_t                state;
  logic [LAT_CNT_W-1:0]  cnt;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_W-1:0]     rsp_rdata_q;

  logic                  accept;
  logic                  misalign;
  logic                  req_err;
  logic [NB-1:0]         mem_we;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     rd_masked;

  logic                  we_p0;
  logic                  err_p0;
  logic [ADDR_W-1:0]     addr_p0;
  logic [NB-1:0]         be_p0;

  assign accept = bus.req_valid && ready_q;

`ifdef BYTE_MEM_ALIGN_CHECK_EN
  assign misalign = (bus.req_addr % ADDR_W'(NB)) != '0;
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (bus.req_be == '0) || misalign;
  // Writes land on the acceptance edge, so a following read never sees stale data.
  assign mem_we  = (accept && bus.req_we && !req_err) ? bus.req_be : '0;

  byte_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .waddr (bus.req_addr),
    .we    (mem_we),
    .wdata (bus.req_wdata),
    .raddr (addr_p0),
    .rdata (mem_rdata)
  );

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < NB; i++) begin
      if (be_p0[i]) rd_masked[8*i +: 8] = mem_rdata[8*i +: 8];
    end
  end

  // Stage p0: request fields captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0   <= bus.req_we;
      err_p0  <= req_err;
      addr_p0 <= bus.req_addr;
      be_p0   <= bus.req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= WAIT;
            ready_q <= 1'b0;
            cnt     <= bus.req_we ? '0 : LAT_CNT_W'(LAT_EFF - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          // First RESP cycle loads the response; it then holds until consumed.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_p0;
            rsp_rdata_q <= (we_p0 || err_p0) ? '0 : rd_masked;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed self-checking bench for byte_mem_ctrl (ADDR_W=10, DATA_W=32, RD_LAT=2).
module tb_byte_mem_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  byte_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  byte_mem_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drives one request, scrambles the request fields after acceptance, and
  // returns cycles from acceptance edge to rsp_valid (-1 on timeout).
  task automatic issue(input logic we, input logic [9:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 0; k < 20 && bus.req_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 10'h155;
    bus.req_be    = ~be;
    bus.req_wdata = 32'h0BADF00D;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 00000000", bus.rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err);
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 10'h010, 4'b1111, 32'hDEADBEEF, lat, rd, er);
    total_cnt++;
    if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (er !== 1'b0 || rd !== 32'h0) $display("FAIL wr_rsp: got err=%b rdata=%h expected err=0 rdata=00000000", er, rd);
    else pass_cnt++;
    issue(1'b0, 10'h010, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (lat !== RD_LAT + 1) $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", rd);
    else pass_cnt++;
    total_cnt++;
    if (er !== 1'b0) $display("FAIL rd_err: got %b expected 0", er);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 10'h040, 4'b1111, 32'hCAFEF00D, lat, rd, er);
    issue(1'b0, 10'h040, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) $display("FAIL raw_data: got %h err=%b expected cafef00d err=0", rd, er);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 10'h020, 4'b1111, 32'hDEADBEEF, lat, rd, er);
    issue(1'b1, 10'h020, 4'b0101, 32'h11223344, lat, rd, er);
    issue(1'b0, 10'h020, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hDE22BE44) $display("FAIL partial_write: got %h expected de22be44", rd);
    else pass_cnt++;
    issue(1'b0, 10'h020, 4'b0011, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h0000BE44) $display("FAIL partial_read_mask: got %h expected 0000be44", rd);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 10'h3FE, 4'b1111, 32'hAABBCCDD, lat, rd, er);
    issue(1'b0, 10'h000, 4'b0011, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h0000AABB) $display("FAIL wrap_low: got %h expected 0000aabb", rd);
    else pass_cnt++;
    issue(1'b0, 10'h3FE, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hAABBCCDD) $display("FAIL wrap_word: got %h expected aabbccdd", rd);
    else pass_cnt++;
    issue(1'b0, 10'h3FF, 4'b0001, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h000000CC) $display("FAIL wrap_top_byte: got %h expected 000000cc", rd);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 10'h014, 4'b1111, 32'h44332211, lat, rd, er);
`ifdef BYTE_MEM_ALIGN_CHECK_EN
    issue(1'b0, 10'h013, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL misalign_read: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd);
    else pass_cnt++;
    issue(1'b1, 10'h013, 4'b1111, 32'h00000000, lat, rd, er);
    total_cnt++;
    if (er !== 1'b1) $display("FAIL misalign_write_err: got %b expected 1", er);
    else pass_cnt++;
    issue(1'b0, 10'h010, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL misalign_no_write_lo: got %h expected deadbeef", rd);
    else pass_cnt++;
    issue(1'b0, 10'h014, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h44332211) $display("FAIL misalign_no_write_hi: got %h expected 44332211", rd);
    else pass_cnt++;
`else
    issue(1'b0, 10'h013, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h332211DE || er !== 1'b0) $display("FAIL misalign_bytewise: got %h err=%b expected 332211de err=0", rd, er);
    else pass_cnt++;
`endif
  endtask

  task automatic test_be_zero();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 10'h010, 4'b0000, 32'h12345678, lat, rd, er);
    total_cnt++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL be0_write: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL be0_write_latency: got %0d expected 2", lat);
    else pass_cnt++;
    issue(1'b0, 10'h010, 4'b0000, 32'h0, lat, rd, er);
    total_cnt++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL be0_read: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd);
    else pass_cnt++;
    issue(1'b0, 10'h010, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL be0_unchanged: got %h err=%b expected deadbeef err=0", rd, er);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    logic seen, ok_stable, ok_ready;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'h010;
    bus.req_be    = 4'b1111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL bp_rsp_seen: got %b expected 1", seen);
    else pass_cnt++;
    // A competing write is offered while the response is held.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h55667788;
    ok_stable = 1'b1;
    ok_ready  = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) ok_stable = 1'b0;
      if (bus.req_ready !== 1'b0) ok_ready = 1'b0;
    end
    total_cnt++;
    if (ok_stable !== 1'b1) $display("FAIL bp_rsp_stable: got %b expected 1", ok_stable);
    else pass_cnt++;
    total_cnt++;
    if (ok_ready !== 1'b1) $display("FAIL bp_req_ready_low: got %b expected 1", ok_ready);
    else pass_cnt++;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", bus.rsp_valid, bus.req_ready);
    else pass_cnt++;
    issue(1'b0, 10'h010, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL bp_no_write: got %h expected deadbeef", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int lat; logic [31:0] rd; logic er;
    logic leaked;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'h020;
    bus.req_be    = 4'b1111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) $display("FAIL rstmid_outputs: got valid=%b rdata=%h expected valid=0 rdata=00000000", bus.rsp_valid, bus.rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL rstmid_req_ready: got %b expected 1", bus.req_ready);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    leaked = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) leaked = 1'b1;
    end
    total_cnt++;
    if (leaked !== 1'b0) $display("FAIL rstmid_no_response: got %b expected 0", leaked);
    else pass_cnt++;
    issue(1'b0, 10'h020, 4'b1111, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hDE22BE44) $display("FAIL rstmid_data_intact: got %h expected de22be44", rd);
    else pass_cnt++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_partial();
`ifndef BYTE_MEM_ALIGN_CHECK_EN
    test_wrap();
`endif
    test_misalign();
    test_be_zero();
    test_backpressure();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
